// File: rtl/rx_pkg.sv
// rx_pkg: shared state type and synchronizer depth for the serial receive path
package rx_pkg;
  localparam int SYNC_STAGES = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, LOAD = 2'd2} rx_state_t;
endpackage

// File: rtl/rx_sr_ctrl_stp.sv
// flex_stp_sr: serial-to-parallel shift register, MSB-first or LSB-first
module flex_stp_sr #(
  parameter int NUM_BITS  = 8,
  parameter bit SHIFT_MSB = 1'b1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                shift_enable,
  input  logic                serial_in,
  output logic [NUM_BITS-1:0] parallel_out
);
  always_ff @(posedge clk)
    if (!n_rst) parallel_out <= '0;
    else if (shift_enable)
      parallel_out <= SHIFT_MSB ? {parallel_out[NUM_BITS-2:0], serial_in}
                                : {serial_in, parallel_out[NUM_BITS-1:1]};
endmodule

// File: rtl/rx_sr_ctrl.sv
// rx_sr_ctrl: synchronizes serial clock/data, assembles words, holds them behind a ready/read handshake
module rx_sr_ctrl
  import rx_pkg::*;
#(
  parameter int NUM_BITS  = 8,
  parameter bit SHIFT_MSB = 1'b1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                sclk_in,
  input  logic                serial_in,
  input  logic                rx_enable,
  input  logic                data_read,
  output logic [NUM_BITS-1:0] rx_data,
  output logic                data_ready,
  output logic                overrun_error
);
  localparam int CNT_W = $clog2(NUM_BITS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_BITS - 1);
  logic [SYNC_STAGES-1:0] r_sclk_sync, r_data_sync;
  logic                   r_sclk_prev;
  logic [CNT_W-1:0]       r_count;
  rx_state_t              r_state;
  rx_state_t              w_next;
  logic                   w_rise, w_shift, w_last;
  logic [NUM_BITS-1:0]    w_sr;
  always_ff @(posedge clk)
    if (!n_rst) begin
      r_sclk_sync <= '0;
      r_data_sync <= '0;
      r_sclk_prev <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_in};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], serial_in};
      r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
    end
  assign w_rise  = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;
  // a rise during LOAD already belongs to the next word
  assign w_shift = w_rise & rx_enable & (r_state != IDLE);
  assign w_last  = (r_state == SHIFT) && (r_count == LAST);
  assign w_next  = (r_state == IDLE) ? (rx_enable ? SHIFT : IDLE) :
                   !rx_enable        ? IDLE :
                   (r_state == LOAD) ? SHIFT :
                   (w_shift && w_last) ? LOAD : SHIFT;
  always_ff @(posedge clk)
    if (!n_rst) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      r_count <= w_shift ? (w_last ? '0 : r_count + CNT_W'(1)) :
                 (w_next == IDLE) ? '0 : r_count;
    end
  flex_stp_sr #(.NUM_BITS(NUM_BITS), .SHIFT_MSB(SHIFT_MSB)) u_sr (
    .clk          (clk),
    .n_rst        (n_rst),
    .shift_enable (w_shift),
    .serial_in    (r_data_sync[SYNC_STAGES-1]),
    .parallel_out (w_sr)
  );
  // a load beats a simultaneous read, so the new word is never lost
  always_ff @(posedge clk)
    if (!n_rst) begin
      rx_data       <= '0;
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
    end else if (r_state == LOAD) begin
      rx_data       <= w_sr;
      data_ready    <= 1'b1;
      overrun_error <= data_ready & ~data_read;
    end else if (data_read && data_ready) begin
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
    end
endmodule

// File: tb/tb_rx_sr_ctrl.sv
// tb_rx_sr_ctrl: directed table, corner sequences and random frames against a frame-level model
module tb_rx_sr_ctrl;
  logic clk = 1'b0, n_rst = 1'b0, sclk = 1'b0, ser = 1'b0, en = 1'b0, rd = 1'b0;
  logic [7:0] rx_m, rx_l;
  logic rdy_m, ovr_m, rdy_l, ovr_l;
  logic pre_rdy, post_rdy;
  int checks = 0, errors = 0;
  logic [7:0] m_data;
  logic m_ready, m_ovr;

  always #5 clk = ~clk;

  rx_sr_ctrl #(.NUM_BITS(8), .SHIFT_MSB(1'b1)) u_msb (
    .clk(clk), .n_rst(n_rst), .sclk_in(sclk), .serial_in(ser), .rx_enable(en),
    .data_read(rd), .rx_data(rx_m), .data_ready(rdy_m), .overrun_error(ovr_m));
  rx_sr_ctrl #(.NUM_BITS(8), .SHIFT_MSB(1'b0)) u_lsb (
    .clk(clk), .n_rst(n_rst), .sclk_in(sclk), .serial_in(ser), .rx_enable(en),
    .data_read(rd), .rx_data(rx_l), .data_ready(rdy_l), .overrun_error(ovr_l));

  typedef struct {
    logic       rd_before;
    int         nbits;
    logic [7:0] word;
    logic       rd_load;
    logic [7:0] exp_data;
    logic       exp_ready;
    logic       exp_ovr;
  } vec_t;

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] ed, input logic er, input logic eo);
    chk({tag, " msb rx_data"}, rx_m, ed);
    chk({tag, " msb data_ready"}, {7'd0, rdy_m}, {7'd0, er});
    chk({tag, " msb overrun"}, {7'd0, ovr_m}, {7'd0, eo});
    chk({tag, " lsb rx_data"}, rx_l, rev8(ed));
    chk({tag, " lsb data_ready"}, {7'd0, rdy_l}, {7'd0, er});
    chk({tag, " lsb overrun"}, {7'd0, ovr_l}, {7'd0, eo});
  endtask

  // Each bit: sclk low 8 clk with data set, then high; data_read optionally pulsed in the LOAD cycle
  task automatic send_frame(input logic [7:0] w, input int nb, input logic rdl);
    for (int i = 0; i < nb; i++) begin
      @(posedge clk); #1 sclk = 1'b0; ser = w[7-i];
      repeat (8) @(posedge clk);
      #1 sclk = 1'b1;
      repeat (3) @(posedge clk);
      #1 pre_rdy = rdy_m; rd = rdl && (i == nb - 1);
      @(posedge clk);
      #1 rd = 1'b0; post_rdy = rdy_m;
      repeat (4) @(posedge clk);
    end
    #1;
  endtask

  task automatic pulse_read;
    @(posedge clk); #1 rd = 1'b1;
    @(posedge clk); #1 rd = 1'b0;
  endtask

  task automatic abort_enable;
    @(posedge clk); #1 en = 1'b0;
    repeat (4) @(posedge clk);
    #1 en = 1'b1;
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1'b1, 8, 8'h3C, 1'b0, 8'h3C, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 8, 8'hC3, 1'b0, 8'hC3, 1'b1, 1'b1};
    tbl[2] = '{1'b1, 0, 8'h00, 1'b0, 8'hC3, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 8, 8'h11, 1'b0, 8'h11, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 8, 8'h33, 1'b0, 8'h33, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 8, 8'h22, 1'b1, 8'h22, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 0, 8'h00, 1'b0, 8'h22, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 8, 8'h99, 1'b1, 8'h99, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    check_all("reset", 8'h00, 1'b0, 1'b0);
    en = 1'b1;

    send_frame(8'hA5, 8, 1'b0);
    chk("A5 ready before load edge", {7'd0, pre_rdy}, 8'h00);
    chk("A5 ready one clk after last shift", {7'd0, post_rdy}, 8'h01);
    check_all("A5 frame", 8'hA5, 1'b1, 1'b0);

    for (int r = 0; r < 8; r++) begin
      if (tbl[r].rd_before) pulse_read();
      if (tbl[r].nbits > 0) send_frame(tbl[r].word, tbl[r].nbits, tbl[r].rd_load);
      repeat (2) @(posedge clk);
      #1 check_all($sformatf("row%0d", r), tbl[r].exp_data, tbl[r].exp_ready, tbl[r].exp_ovr);
    end

    pulse_read();
    send_frame(8'b1010_0000, 3, 1'b0);
    abort_enable();
    check_all("abort untouched", 8'h99, 1'b0, 1'b0);
    send_frame(8'h81, 8, 1'b0);
    check_all("after abort", 8'h81, 1'b1, 1'b0);

    send_frame(8'hFF, 5, 1'b0);
    @(posedge clk); #1 sclk = 1'b0;
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b0;
    @(posedge clk); #1 n_rst = 1'b1;
    check_all("mid-word reset", 8'h00, 1'b0, 1'b0);
    send_frame(8'h5A, 8, 1'b0);
    check_all("after reset frame", 8'h5A, 1'b1, 1'b0);

    m_data = 8'h5A; m_ready = 1'b1; m_ovr = 1'b0;
    for (int it = 0; it < 24; it++) begin
      logic [7:0] w;
      logic rdl;
      if ($urandom_range(0, 3) == 0) begin
        send_frame(8'($urandom), int'($urandom_range(1, 7)), 1'b0);
        abort_enable();
      end
      if ($urandom_range(0, 1) == 1) begin
        pulse_read();
        if (m_ready) begin m_ready = 1'b0; m_ovr = 1'b0; end
      end
      w = 8'($urandom);
      rdl = 1'($urandom_range(0, 1));
      send_frame(w, 8, rdl);
      m_ovr = m_ready && !rdl;
      m_ready = 1'b1;
      m_data = w;
      check_all($sformatf("rand%0d", it), m_data, m_ready, m_ovr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
